// File: rtl/pc_update_unit_if.sv
// Request/status bundle between the control unit and the PC write stage.
// The master side issues requests; the slave side is pc_update_unit.
interface pc_update_unit_if #(
  parameter int PC_WIDTH   = 32,
  parameter int STAT_WIDTH = 16
);
  logic                  PCWrite;
  logic                  PCWriteCond;
  logic                  branch_taken;
  logic [1:0]            PCSource;
  logic [PC_WIDTH-1:0]   pc_plus4;
  logic [PC_WIDTH-1:0]   alu_out;
  logic [25:0]           jump_field;
  logic                  clr_misaligned;
  logic [PC_WIDTH-1:0]   pc;
  logic                  busy;
  logic                  done;
  logic                  misaligned;
  logic [STAT_WIDTH-1:0] taken_cnt;
  logic [STAT_WIDTH-1:0] nottaken_cnt;

  modport master (
    output PCWrite, PCWriteCond, branch_taken, PCSource, pc_plus4, alu_out,
           jump_field, clr_misaligned,
    input  pc, busy, done, misaligned, taken_cnt, nottaken_cnt
  );

  modport slave (
    input  PCWrite, PCWriteCond, branch_taken, PCSource, pc_plus4, alu_out,
           jump_field, clr_misaligned,
    output pc, busy, done, misaligned, taken_cnt, nottaken_cnt
  );
endinterface

// File: rtl/pc_update_unit.sv
// Multicycle PC write stage: capture request, evaluate take/alignment, commit the PC.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module pc_update_unit #(
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR = 32'h0000_00FC,
  parameter int                  STAT_WIDTH = 16
) (
  input logic             clk,
  input logic             reset_n,
  pc_update_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_t;

  state_t              state, state_nxt;
  logic                req;
  logic [PC_WIDTH-1:0] sel_tgt;
  logic [PC_WIDTH-1:0] tgt_p1;
  logic [1:0]          src_p1;
  logic                take_p1;
  logic                misal_hit;
  logic                done_nxt;
  logic                mis_set;
  logic                pc_we;
  logic [PC_WIDTH-1:0] pc_r;
  logic                done_r;
  logic                mis_r;

  assign req = bus.PCWrite | bus.PCWriteCond;

  always_comb begin
    sel_tgt = bus.pc_plus4;
    case (bus.PCSource)
      2'b00:   sel_tgt = bus.pc_plus4;
      2'b01:   sel_tgt = bus.alu_out;
      2'b10:   sel_tgt = {bus.pc_plus4[PC_WIDTH-1:PC_WIDTH-4], bus.jump_field, 2'b00};
      default: sel_tgt = EXC_VECTOR;
    endcase
  end

  // Capture stage: request fields latched while IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      take_p1 <= 1'b0;
      src_p1  <= 2'b00;
    end else if (state == IDLE && req) begin
      take_p1 <= bus.PCWrite | (bus.PCWriteCond & bus.branch_taken);
      src_p1  <= bus.PCSource;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) tgt_p1 <= sel_tgt;
  end

  // Exception vector is trusted aligned; jump targets are aligned by construction
  assign misal_hit = take_p1 && (src_p1 != 2'b11) && (tgt_p1[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = EVAL;
      EVAL:    state_nxt = (!take_p1 || misal_hit) ? IDLE : COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done_nxt = 1'b0;
    mis_set  = 1'b0;
    pc_we    = 1'b0;
    case (state)
      EVAL: begin
        if (!take_p1) begin
          done_nxt = 1'b1;
        end else if (misal_hit) begin
          done_nxt = 1'b1;
          mis_set  = 1'b1;
        end
      end
      COMMIT: begin
        done_nxt = 1'b1;
        pc_we    = 1'b1;
      end
      default: ;
    endcase
  end

  // Commit stage: PC, done pulse and sticky misaligned flag (set beats clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r   <= RESET_PC;
      done_r <= 1'b0;
      mis_r  <= 1'b0;
    end else begin
      done_r <= done_nxt;
      if (pc_we) pc_r <= tgt_p1;
      if (mis_set)                 mis_r <= 1'b1;
      else if (bus.clr_misaligned) mis_r <= 1'b0;
    end
  end

  assign bus.pc         = pc_r;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_r;
  assign bus.misaligned = mis_r;

`ifdef BRANCH_STATS_EN
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                  cond_p1;
  logic [STAT_WIDTH-1:0] taken_r;
  logic [STAT_WIDTH-1:0] nottaken_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cond_p1    <= 1'b0;
      taken_r    <= '0;
      nottaken_r <= '0;
    end else begin
      if (state == IDLE && req) cond_p1 <= bus.PCWriteCond & ~bus.PCWrite;
      if (state == EVAL && cond_p1) begin
        if (take_p1) taken_r    <= sat_inc(taken_r);
        else         nottaken_r <= sat_inc(nottaken_r);
      end
    end
  end

  assign bus.taken_cnt    = taken_r;
  assign bus.nottaken_cnt = nottaken_r;
`else
  assign bus.taken_cnt    = '0;
  assign bus.nottaken_cnt = '0;
`endif

endmodule
